// File: rtl/bus_response_checker_pkg.sv
// Shared types and the golden vote function for the bus response checker.
// The optional seen-code coverage logic is enabled by BUS_CHK_COVERAGE_EN.
package bus_chk_pkg;

  localparam int VEC_W           = 4;
  localparam int NUM_CODES       = 1 << VEC_W;
  localparam int DEF_NUM_VECTORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Golden four-input vote: 1 when at least three of the inputs are 1.
  function automatic logic expected_out(input logic [VEC_W-1:0] v);
    logic [2:0] ones;
    ones = 3'd0;
    for (int i = 0; i < VEC_W; i++) begin
      ones = ones + {2'b00, v[i]};
    end
    return (ones >= 3'd3);
  endfunction

endpackage

// File: rtl/bus_response_checker_if.sv
// Vector handshake bus between the stimulus side (master) and the checker (slave).
// The port list is identical whether or not BUS_CHK_COVERAGE_EN is defined.
interface bus_response_checker_if;
  import bus_chk_pkg::*;

  logic             vec_valid;
  logic             vec_ready;
  logic [VEC_W-1:0] vec;

  modport master (output vec_valid, output vec, input vec_ready);
  modport slave  (input vec_valid, input vec, output vec_ready);

endinterface

// File: rtl/bus_response_checker_ref_model.sv
// Purely combinational reference: captured vector in, expected vote bit out.
// Also instantiated by the bench so both sides use the same golden function.
module bus_chk_ref_model
  import bus_chk_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             exp_o
);

  assign exp_o = expected_out(vec_i);

endmodule

// File: rtl/bus_response_checker.sv
// Receiving-end checker for the four-input vote DUT: accepts one vector per
// handshake, waits SETTLE_CYCLES, compares dut_out to the golden vote, and
// keeps counts, the first failing vector and a done/pass verdict.
// Optional seen-code coverage (cov_full) is enabled by BUS_CHK_COVERAGE_EN;
// without it cov_full is tied low.
module bus_response_checker
  import bus_chk_pkg::*;
#(
  parameter int NUM_VECTORS   = DEF_NUM_VECTORS,
  parameter int CNT_W         = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  bus_response_checker_if.slave  bus,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       vec_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   first_fail_valid,
  output logic [VEC_W-1:0]       first_fail_vec,
  output logic                   cov_full
);

  localparam int               SET_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VECTORS);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             ffv_q, ffv_d;
  logic [VEC_W-1:0] ffvec_q, ffvec_d;
  logic             pass_q, pass_d;
  logic             exp_s;
  logic             start_run_s;

  bus_chk_ref_model u_ref (
    .vec_i (vec_q),
    .exp_o (exp_s)
  );

  assign start_run_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Next-state and datapath updates for the capture/settle/compare sequence.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    set_cnt_d   = set_cnt_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ffv_d       = ffv_q;
    ffvec_d     = ffvec_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_count_d = '0;
          err_count_d = '0;
          ffv_d       = 1'b0;
          ffvec_d     = '0;
          pass_d      = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT: begin
        if (bus.vec_valid) begin
          vec_d     = bus.vec;
          set_cnt_d = SET_LOAD;
          state_d   = ST_SETTLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == SET_ONE) begin
          state_d = ST_COMPARE;
        end else begin
          set_cnt_d = set_cnt_q - SET_ONE;
        end
      end
      ST_COMPARE: begin
        vec_count_d = vec_count_q + CNT_ONE;
        if (dut_out != exp_s) begin
          err_count_d = (err_count_q == CNT_MAX) ? err_count_q : (err_count_q + CNT_ONE);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end else begin
            ffv_d = ffv_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        if (vec_count_d == CNT_LAST) begin
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      set_cnt_q   <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      ffv_q       <= 1'b0;
      ffvec_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      set_cnt_q   <= set_cnt_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      ffv_q       <= ffv_d;
      ffvec_q     <= ffvec_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.vec_ready     = (state_q == ST_WAIT);
  assign busy              = (state_q == ST_WAIT) || (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
  assign done              = (state_q == ST_DONE);
  assign pass              = pass_q;
  assign vec_count         = vec_count_q;
  assign err_count         = err_count_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_vec    = ffvec_q;

`ifdef BUS_CHK_COVERAGE_EN
  logic [NUM_CODES-1:0] mask_q, mask_d;
  logic                 cov_q;

  // Seen-code mask: cleared when a run starts, marked at every compare.
  always_comb begin
    mask_d = mask_q;
    if (start_run_s) begin
      mask_d = '0;
    end else if (state_q == ST_COMPARE) begin
      mask_d[vec_q] = 1'b1;
    end else begin
      mask_d = mask_q;
    end
  end

  // Mask register and its registered all-codes-seen flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cov_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cov_q  <= &mask_d;
    end
  end

  assign cov_full = cov_q;
`else
  assign cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_bus_response_checker.sv
// Directed bench for bus_response_checker: golden, single-fault, stuck-at,
// back-to-back, mid-run reset and (with BUS_CHK_COVERAGE_EN) coverage runs.
module tb_bus_response_checker;
  import bus_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start3, dut_out1, dut_out3;
  logic       busy1, done1, pass1, ffv1, cov1;
  logic       busy3, done3, pass3, ffv3, cov3;
  logic [4:0] vc1, ec1, vc3, ec3;
  logic [3:0] ffvec1, ffvec3;
  logic [3:0] ref_vec;
  logic       ref_exp;
  logic [15:0] gold;
  int total = 0;
  int passed = 0;
  int failed = 0;

  bus_response_checker_if bus1 ();
  bus_response_checker_if bus3 ();

  bus_response_checker #(.NUM_VECTORS(16), .CNT_W(5), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .cov_full(cov1)
  );

  bus_response_checker #(.NUM_VECTORS(16), .CNT_W(5), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bus(bus3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .vec_count(vc3), .err_count(ec3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3), .cov_full(cov3)
  );

  bus_chk_ref_model u_ref (.vec_i(ref_vec), .exp_o(ref_exp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one vector to dut1; the response is applied once the vector is taken.
  task automatic send_vec(input logic [3:0] code, input logic resp);
    bus1.vec       = code;
    bus1.vec_valid = 1'b1;
    for (int k = 0; k < 20 && bus1.vec_ready !== 1'b1; k++) @(negedge clk);
    chk("ready_wait", {31'd0, bus1.vec_ready}, 32'd1);
    @(negedge clk);
    bus1.vec_valid = 1'b0;
    dut_out1       = resp;
  endtask

  // Full 16-vector run on dut1; codes packed as nibbles, resp bit i for vector i.
  task automatic run1(input logic [63:0] codes, input logic [15:0] resp);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("start_clr", {19'd0, vc1, ec1, ffv1, done1, cov1}, 32'd0);
    for (int i = 0; i < 16; i++) send_vec(codes[4*i +: 4], resp[i]);
    for (int k = 0; k < 20 && done1 !== 1'b1; k++) @(negedge clk);
    chk("done", {31'd0, done1}, 32'd1);
  endtask

  initial begin
    int cyc, first, last, low;
    logic upd;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; dut_out1 = 1'b0; dut_out3 = 1'b0;
    bus1.vec_valid = 1'b0; bus1.vec = 4'h0; bus3.vec_valid = 1'b0; bus3.vec = 4'h0;
    gold = 16'hE880;

    for (int i = 0; i < 16; i++) begin
      ref_vec = 4'(i);
      #1;
      chk("ref_model", {31'd0, ref_exp}, {31'd0, gold[i]});
    end

    repeat (2) @(negedge clk);
    chk("reset_out1", {17'd0, busy1, done1, pass1, bus1.vec_ready, vc1, ec1, ffv1, ffvec1, cov1}, 32'd0);
    chk("reset_out3", {17'd0, busy3, done3, pass3, bus3.vec_ready, vc3, ec3, ffv3, ffvec3, cov3}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {30'd0, busy1, bus1.vec_ready}, 32'd0);

    // Golden run
    run1(64'hFEDC_BA98_7654_3210, 16'hE880);
    chk("gold_vc", 32'(vc1), 32'd16);
    chk("gold_ec", 32'(ec1), 32'd0);
    chk("gold_pass", {31'd0, pass1}, 32'd1);
    chk("gold_ffv", {31'd0, ffv1}, 32'd0);
    chk("gold_idle_out", {30'd0, busy1, bus1.vec_ready}, 32'd0);
`ifdef BUS_CHK_COVERAGE_EN
    chk("cov_all", {31'd0, cov1}, 32'd1);
`else
    chk("cov_tied", {31'd0, cov1}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("done_held", {31'd0, done1}, 32'd1);

    // Single fault on code 7
    run1(64'hFEDC_BA98_7654_3210, 16'hE800);
    chk("sf_ec", 32'(ec1), 32'd1);
    chk("sf_ffv", {31'd0, ffv1}, 32'd1);
    chk("sf_ffvec", 32'(ffvec1), 32'd7);
    chk("sf_pass", {31'd0, pass1}, 32'd0);

    // Stuck-at-1 response
    run1(64'hFEDC_BA98_7654_3210, 16'hFFFF);
    chk("sa1_ec", 32'(ec1), 32'd11);
    chk("sa1_ffvec", 32'(ffvec1), 32'd0);
    chk("sa1_pass", {31'd0, pass1}, 32'd0);

    // Stuck-at-0 response
    run1(64'hFEDC_BA98_7654_3210, 16'h0000);
    chk("sa0_ec", 32'(ec1), 32'd5);
    chk("sa0_ffvec", 32'(ffvec1), 32'd7);
    chk("sa0_vc", 32'(vc1), 32'd16);

    // Code 9 replaced by a duplicate 3
    run1(64'hFEDC_BA38_7654_3210, 16'hE880);
    chk("dup_ec", 32'(ec1), 32'd0);
    chk("dup_cov", {31'd0, cov1}, 32'd0);

    // Reset after five compares
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) send_vec(4'(i), gold[i]);
    for (int k = 0; k < 20 && vc1 !== 5'd5; k++) @(negedge clk);
    chk("mid_vc5", 32'(vc1), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {17'd0, busy1, done1, pass1, bus1.vec_ready, vc1, ec1, ffv1, ffvec1, cov1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus1.vec_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_run", {25'd0, busy1, bus1.vec_ready, vc1}, 32'd0);
    bus1.vec_valid = 1'b0;
    run1(64'hFEDC_BA98_7654_3210, 16'hE880);
    chk("mid_rerun_vc", 32'(vc1), 32'd16);
    chk("mid_rerun_pass", {31'd0, pass1}, 32'd1);

    // Back-to-back on the SETTLE_CYCLES=3 instance
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    bus3.vec = 4'h0; bus3.vec_valid = 1'b1;
    cyc = 0; first = -1; last = -1; low = 0; upd = 1'b0;
    while (done3 !== 1'b1 && cyc < 200) begin
      if (upd) begin
        dut_out3 = gold[bus3.vec];
        bus3.vec = bus3.vec + 4'd1;
        upd = 1'b0;
      end
      if (bus3.vec_ready === 1'b1) begin
        if (last >= 0) begin
          chk("b2b_gap", 32'(cyc - last), 32'd5);
          chk("b2b_low", 32'(low), 32'd4);
        end else begin
          first = cyc;
        end
        last = cyc; low = 0; upd = 1'b1;
      end else if (last >= 0) begin
        low++;
      end
      if (first >= 0 && cyc - first == 79) chk("b2b_vc15", 32'(vc3), 32'd15);
      @(negedge clk);
      cyc++;
    end
    bus3.vec_valid = 1'b0;
    chk("b2b_done", {31'd0, done3}, 32'd1);
    chk("b2b_80cyc", 32'(cyc - first), 32'd80);
    chk("b2b_vc", 32'(vc3), 32'd16);
    chk("b2b_ec", 32'(ec3), 32'd0);
    chk("b2b_pass", {31'd0, pass3}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_response_checker.md
Name: bus_response_checker

Overview:
- Receiving-end counterpart of the four-input vote bus stimulus path.
- Accepts one 4-bit vector per valid/ready handshake and waits a settle delay. It then samples the DUT output and compares it against the golden function: out = 1 iff at least 3 of {A,B,C,D} are 1.
- Counts vectors and mismatches, captures the first failing vector, and reports done/pass.
- Sits beside the DUT in synthesizable self-test benches and on-chip BIST.

Parameters:
- NUM_VECTORS, 16, vectors per run before done; range 1..2^CNT_W-1.
- CNT_W, 5, width of vec_count and err_count.
- SETTLE_CYCLES, 1, cycles between vector capture and the compare cycle; must be >=1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- vec_valid  in  1  a vector is offered.
- vec_ready  out  1  checker can accept a vector.
- vec  in  4  vec[3]=A, vec[2]=B, vec[1]=C, vec[0]=D.
- dut_out  in  1  DUT response to the captured vector.
- busy  out  1  a run is in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  valid only while done=1; 1 iff err_count==0.
- vec_count  out  CNT_W  vectors compared this run.
- err_count  out  CNT_W  mismatches; saturates at all-ones.
- first_fail_valid  out  1  first_fail_vec holds a captured failure.
- first_fail_vec  out  4  vector of the first mismatch.
- cov_full  out  1  all 16 vector codes seen this run (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0, including vec_ready, done, pass, counts, first_fail_*, cov_full.
- States: IDLE, WAIT, SETTLE, COMPARE, DONE.
- IDLE/DONE, on start:
  - clear vec_count, err_count, first_fail_*, pass, done and the coverage mask;
  - go to WAIT.
  - start in any other state is ignored.
- WAIT:
  - vec_ready=1, busy=1.
  - On edge E0 with vec_valid&vec_ready: register vec into vec_q, load the settle counter with SETTLE_CYCLES, go to SETTLE, drop vec_ready.
  - vec is ignored when vec_valid=0.
- SETTLE: decrement each cycle; go to COMPARE when the counter reaches 1.
- COMPARE (one cycle):
  - sample dut_out at the closing edge, i.e. edge E0+SETTLE_CYCLES+1;
  - compute expected = (popcount(vec_q) >= 3);
  - vec_count += 1; on mismatch, err_count += 1 (saturating);
  - on the first mismatch of the run, set first_fail_valid=1 and first_fail_vec=vec_q.
  - If the new vec_count==NUM_VECTORS, go to DONE; else go to WAIT.
- Throughput: one vector per SETTLE_CYCLES+2 cycles; vec_ready is low for SETTLE_CYCLES+1 cycles after each acceptance.
- DONE:
  - done=1, busy=0, vec_ready=0;
  - pass registered on DONE entry as (final err_count==0);
  - counts and first_fail_* held.
- vec_valid outside WAIT: not accepted; the offering side must hold the vector until vec_ready.
- err_count saturation: stays at all-ones; pass stays 0.
- Reset mid-run: run abandoned; all state cleared; a new start is needed.

Optional Feature:
- Macro: BUS_CHK_COVERAGE_EN.
- Defined:
  - 16-bit seen mask, cleared on start;
  - bit vec_q set at each COMPARE;
  - cov_full registered = (&mask).
- Undefined: mask logic omitted; cov_full tied to 0. The port list is identical in both builds.

Decomposition:
- Package bus_chk_pkg:
  - state enum (IDLE, WAIT, SETTLE, COMPARE, DONE);
  - default NUM_VECTORS=16;
  - VEC_W=4 constant;
  - golden function expected_out(vec).
- One sub-module, bus_chk_ref_model: purely combinational 4-bit vector -> expected bit. It is shared with the bench scoreboard.

Test Plan:
- Golden run: start, then vectors 0..15 with dut_out=golden, SETTLE_CYCLES=1. Expect done after 16 compares, vec_count=16, err_count=0, pass=1, first_fail_valid=0.
- Single fault: as the golden run, but dut_out=0 for vec 4'b0111. Expect err_count=1, first_fail_vec=4'h7, pass=0.
- Stuck-at-1: dut_out=1 for all 16 vectors. Expect err_count=11 (the 16 codes minus the five 1-results 7,B,D,E,F), first_fail_vec=4'h0.
- Back-to-back: vec_valid held high, SETTLE_CYCLES=3. Expect acceptances exactly 5 cycles apart, vec_ready low 4 cycles after each, vec_count=16 after 80 cycles.
- Reset mid-run: assert rst_n=0 after 5 compares. Expect all outputs 0 immediately; after release, start is ignored until pulsed again, and a new run counts from 0.
- Coverage (macro defined): 16 vectors with code 9 replaced by a duplicate 3 -> cov_full=0. All 16 distinct codes -> cov_full=1 on the cycle after the last COMPARE.
